// File: rtl/dff_bank_pkg.sv
// Shared types and width helpers for the arbitrated flop bank.
package dff_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  function automatic int OWNER_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/dff_bank_arb_rr_pick.sv
// Combinational round-robin select: first request after ptr, wrapping.
module rr_pick
  import dff_bank_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]              req,
  input  logic [OWNER_W(NREQ)-1:0]     ptr,
  output logic [NREQ-1:0]              pick,
  output logic [OWNER_W(NREQ)-1:0]     pick_idx,
  output logic                         any
);

  localparam int OW = OWNER_W(NREQ);

  logic [OW-1:0] cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = OW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        pick[cand]  = 1'b1;
        pick_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arb.sv
// Round-robin write arbiter for a shared flop bank with complementary outputs.
//   state    | meaning
//   ST_IDLE  | no grant outstanding
//   ST_BUSY  | one requester owns the bank, bounded to HOLD writes
//   ST_CLEAR | one-cycle bubble after a clear
module dff_bank_arb
  import dff_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  input  logic                     clr,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qb,
  output logic                     valid
);

  localparam int OW = OWNER_W(NREQ);
  localparam int HW = cnt_w(HOLD);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    left_q, left_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;

  logic [NREQ-1:0]  pick;
  logic [OW-1:0]    pick_idx;
  logic             pick_any;
  logic             xfer;
  logic [WIDTH-1:0] wsel;

  // Candidates exclude the current owner so rotation never re-picks it.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (req & ~gnt_q),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign xfer = |(req & gnt_q);

  always_comb begin
    wsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) wsel = wsel | wdata[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    q_d     = q_q;
    valid_d = valid_q;

    if (clr) begin
      q_d     = '0;
      valid_d = 1'b0;
      gnt_d   = '0;
      left_d  = '0;
      state_d = ST_CLEAR;
    end else begin
      if (xfer) begin
        q_d     = wsel;
        valid_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_d   = pick;
            owner_d = pick_idx;
            ptr_d   = pick_idx;
            left_d  = HW'(HOLD);
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!xfer) begin
            // Owner released: hand over on this edge or fall back to idle.
            if (pick_any) begin
              gnt_d   = pick;
              owner_d = pick_idx;
              ptr_d   = pick_idx;
              left_d  = HW'(HOLD);
            end else begin
              gnt_d   = '0;
              left_d  = '0;
              state_d = ST_IDLE;
            end
          end else if (left_q == HW'(1)) begin
            left_d = HW'(HOLD);
            if (pick_any) begin
              gnt_d   = pick;
              owner_d = pick_idx;
              ptr_d   = pick_idx;
            end
          end else begin
            left_d = left_q - HW'(1);
          end
        end
        ST_CLEAR: begin
          state_d = ST_IDLE;
        end
        default: begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(NREQ - 1);
      left_q  <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign q     = q_q;
  assign qb    = ~q_q;
  assign valid = valid_q;

endmodule
